// File: rtl/wrp_tap_pkg.sv
// Shared TAP definitions: state encoding, default opcodes, config TDR layout.
package wrp_tap_pkg;

  localparam int         IR_LEN_DEF     = 4;
  localparam logic [3:0] OP_INSCAN_DEF  = 4'h2;
  localparam logic [3:0] OP_OUTSCAN_DEF = 4'h3;
  localparam logic [3:0] OP_WRPCFG_DEF  = 4'h4;

  typedef enum logic [3:0] {
    TS_TLR       = 4'h0,
    TS_RTI       = 4'h1,
    TS_SEL_DR    = 4'h2,
    TS_CAP_DR    = 4'h3,
    TS_SHIFT_DR  = 4'h4,
    TS_EXIT1_DR  = 4'h5,
    TS_PAUSE_DR  = 4'h6,
    TS_EXIT2_DR  = 4'h7,
    TS_UPDATE_DR = 4'h8,
    TS_SEL_IR    = 4'h9,
    TS_CAP_IR    = 4'hA,
    TS_SHIFT_IR  = 4'hB,
    TS_EXIT1_IR  = 4'hC,
    TS_PAUSE_IR  = 4'hD,
    TS_EXIT2_IR  = 4'hE,
    TS_UPDATE_IR = 4'hF
  } tap_state_e;

  // Config TDR, bit0 = wrp_if
  typedef struct packed {
    logic safe_val;
    logic inscanwrap_sel;
    logic wrp_of;
    logic wrp_if;
  } wrp_cfg_t;

endpackage

// File: rtl/wrp_cfg_tdr.sv
// Wrapper config TDR: 4-bit shift stage plus update stage driving the config outputs.
module wrp_cfg_tdr
  import wrp_tap_pkg::*;
(
  input  logic     TDR_TCK,
  input  logic     TDR_TRESETN,
  input  logic     i_sel,
  input  logic     i_capture,
  input  logic     i_shift,
  input  logic     i_update,
  input  logic     i_clear,
  input  logic     i_tdi,
  output logic     o_so,
  output wrp_cfg_t o_cfg
);

  logic [3:0] r_sr;
  logic [3:0] r_upd;

  // shift stage: capture the live config, then shift LSB-first toward TDO
  always_ff @(posedge TDR_TCK or negedge TDR_TRESETN) begin
    if (!TDR_TRESETN)            r_sr <= '0;
    else if (i_sel && i_capture) r_sr <= r_upd;
    else if (i_sel && i_shift)   r_sr <= {i_tdi, r_sr[3:1]};
  end

  // update stage: only moves on Update-DR while selected, cleared in TLR
  always_ff @(negedge TDR_TCK or negedge TDR_TRESETN) begin
    if (!TDR_TRESETN)           r_upd <= '0;
    else if (i_clear)           r_upd <= '0;
    else if (i_sel && i_update) r_upd <= r_sr;
  end

  assign o_so  = r_sr[0];
  assign o_cfg = wrp_cfg_t'(r_upd);

endmodule

// File: rtl/wrp_tap_ctrl.sv
// IEEE 1149.1 TAP controller for the wrapper: IR, bypass, config TDR, chain selects.
//
// state        | meaning
// TS_TLR       | test-logic-reset, IR forced to BYPASS, config cleared
// TS_RTI       | run-test/idle
// TS_SEL_DR    | select DR scan
// TS_CAP_DR    | capture into selected DR, TDR_CAPTURE high
// TS_SHIFT_DR  | shift selected DR, TDR_SHIFT high
// TS_EXIT1_DR  | exit1 DR
// TS_PAUSE_DR  | pause DR
// TS_EXIT2_DR  | exit2 DR
// TS_UPDATE_DR | update selected DR on negedge, TDR_UPDATE high
// TS_SEL_IR    | select IR scan
// TS_CAP_IR    | IR shift register loaded with 'b0..01
// TS_SHIFT_IR  | shift IR
// TS_EXIT1_IR  | exit1 IR
// TS_PAUSE_IR  | pause IR
// TS_EXIT2_IR  | exit2 IR
// TS_UPDATE_IR | IR (and chain enables) loaded on negedge
module wrp_tap_ctrl
  import wrp_tap_pkg::*;
#(
  parameter int                IR_LEN     = IR_LEN_DEF,
  parameter logic [IR_LEN-1:0] OP_INSCAN  = IR_LEN'(OP_INSCAN_DEF),
  parameter logic [IR_LEN-1:0] OP_OUTSCAN = IR_LEN'(OP_OUTSCAN_DEF),
  parameter logic [IR_LEN-1:0] OP_WRPCFG  = IR_LEN'(OP_WRPCFG_DEF)
) (
  input  logic TDR_TCK,
  input  logic TDR_TRESETN,
  input  logic TMS,
  input  logic TDI,
  input  logic WRP_SO,
  output logic TDO,
  output logic TDO_EN,
  output logic TDR_CAPTURE,
  output logic TDR_SHIFT,
  output logic TDR_UPDATE,
  output logic INSCANWRAP_TDR_EN,
  output logic OUTSCANWRAP_TDR_EN,
  output logic WRP_SI,
  output logic safe_val,
  output logic inscanwrap_sel,
  output logic wrp_of,
  output logic wrp_if
);

  tap_state_e        r_state;
  tap_state_e        w_state_nxt;
  logic [IR_LEN-1:0] r_ir_sr;
  logic [IR_LEN-1:0] r_ir;
  logic              r_inscan_en;
  logic              r_outscan_en;
  logic              r_bypass;
  logic              r_tdo;
  logic              r_tdo_en;
  logic              w_tlr, w_cap_dr, w_shift_dr, w_upd_dr;
  logic              w_cap_ir, w_shift_ir, w_upd_ir;
  logic              w_sel_cfg, w_sel_chain;
  logic              w_cfg_so;
  logic              w_tdo;
  wrp_cfg_t          w_cfg;

  // state register
  always_ff @(posedge TDR_TCK or negedge TDR_TRESETN) begin
    if (!TDR_TRESETN) r_state <= TS_TLR;
    else              r_state <= w_state_nxt;
  end

  // next-state decode per TMS
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TS_TLR:       w_state_nxt = TMS ? TS_TLR      : TS_RTI;
      TS_RTI:       w_state_nxt = TMS ? TS_SEL_DR   : TS_RTI;
      TS_SEL_DR:    w_state_nxt = TMS ? TS_SEL_IR   : TS_CAP_DR;
      TS_CAP_DR:    w_state_nxt = TMS ? TS_EXIT1_DR : TS_SHIFT_DR;
      TS_SHIFT_DR:  w_state_nxt = TMS ? TS_EXIT1_DR : TS_SHIFT_DR;
      TS_EXIT1_DR:  w_state_nxt = TMS ? TS_UPDATE_DR : TS_PAUSE_DR;
      TS_PAUSE_DR:  w_state_nxt = TMS ? TS_EXIT2_DR : TS_PAUSE_DR;
      TS_EXIT2_DR:  w_state_nxt = TMS ? TS_UPDATE_DR : TS_SHIFT_DR;
      TS_UPDATE_DR: w_state_nxt = TMS ? TS_SEL_DR   : TS_RTI;
      TS_SEL_IR:    w_state_nxt = TMS ? TS_TLR      : TS_CAP_IR;
      TS_CAP_IR:    w_state_nxt = TMS ? TS_EXIT1_IR : TS_SHIFT_IR;
      TS_SHIFT_IR:  w_state_nxt = TMS ? TS_EXIT1_IR : TS_SHIFT_IR;
      TS_EXIT1_IR:  w_state_nxt = TMS ? TS_UPDATE_IR : TS_PAUSE_IR;
      TS_PAUSE_IR:  w_state_nxt = TMS ? TS_EXIT2_IR : TS_PAUSE_IR;
      TS_EXIT2_IR:  w_state_nxt = TMS ? TS_UPDATE_IR : TS_SHIFT_IR;
      TS_UPDATE_IR: w_state_nxt = TMS ? TS_SEL_DR   : TS_RTI;
      default:      w_state_nxt = TS_TLR;
    endcase
  end

  // phase strobes decoded straight from the state register
  always_comb begin
    w_tlr      = (r_state == TS_TLR);
    w_cap_dr   = (r_state == TS_CAP_DR);
    w_shift_dr = (r_state == TS_SHIFT_DR);
    w_upd_dr   = (r_state == TS_UPDATE_DR);
    w_cap_ir   = (r_state == TS_CAP_IR);
    w_shift_ir = (r_state == TS_SHIFT_IR);
    w_upd_ir   = (r_state == TS_UPDATE_IR);
  end

  // IR shift register: capture 'b0..01, shift LSB-first
  always_ff @(posedge TDR_TCK or negedge TDR_TRESETN) begin
    if (!TDR_TRESETN)    r_ir_sr <= '0;
    else if (w_cap_ir)   r_ir_sr <= IR_LEN'(1);
    else if (w_shift_ir) r_ir_sr <= {TDI, r_ir_sr[IR_LEN-1:1]};
  end

  // IR and chain enables share one negedge register so the enables never glitch
  always_ff @(negedge TDR_TCK or negedge TDR_TRESETN) begin
    if (!TDR_TRESETN || w_tlr) begin
      r_ir         <= '1;
      r_inscan_en  <= 1'b0;
      r_outscan_en <= 1'b0;
    end else if (w_upd_ir) begin
      r_ir         <= r_ir_sr;
      r_inscan_en  <= (r_ir_sr == OP_INSCAN);
      r_outscan_en <= (r_ir_sr == OP_OUTSCAN) && (r_ir_sr != OP_INSCAN);
    end
  end

  // undefined opcodes fall through to the bypass bit
  assign w_sel_cfg   = (r_ir == OP_WRPCFG);
  assign w_sel_chain = r_inscan_en | r_outscan_en;

  // bypass bit
  always_ff @(posedge TDR_TCK or negedge TDR_TRESETN) begin
    if (!TDR_TRESETN)    r_bypass <= 1'b0;
    else if (w_cap_dr)   r_bypass <= 1'b0;
    else if (w_shift_dr) r_bypass <= TDI;
  end

  wrp_cfg_tdr u_cfg_tdr (
    .TDR_TCK     (TDR_TCK),
    .TDR_TRESETN (TDR_TRESETN),
    .i_sel       (w_sel_cfg),
    .i_capture   (w_cap_dr),
    .i_shift     (w_shift_dr),
    .i_update    (w_upd_dr),
    .i_clear     (w_tlr),
    .i_tdi       (TDI),
    .o_so        (w_cfg_so),
    .o_cfg       (w_cfg)
  );

  // TDO source select
  always_comb begin
    w_tdo = r_bypass;
    if (w_shift_ir)       w_tdo = r_ir_sr[0];
    else if (w_sel_chain) w_tdo = WRP_SO;
    else if (w_sel_cfg)   w_tdo = w_cfg_so;
  end

  // TDO and its enable launched on the falling edge
  always_ff @(negedge TDR_TCK or negedge TDR_TRESETN) begin
    if (!TDR_TRESETN) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo    <= w_tdo;
      r_tdo_en <= w_shift_ir | w_shift_dr;
    end
  end

  assign TDO                = r_tdo;
  assign TDO_EN             = r_tdo_en;
  assign TDR_CAPTURE        = w_cap_dr;
  assign TDR_SHIFT          = w_shift_dr;
  assign TDR_UPDATE         = w_upd_dr;
  assign INSCANWRAP_TDR_EN  = r_inscan_en;
  assign OUTSCANWRAP_TDR_EN = r_outscan_en;
  assign WRP_SI             = TDI;
  assign safe_val           = w_cfg.safe_val;
  assign inscanwrap_sel     = w_cfg.inscanwrap_sel;
  assign wrp_of             = w_cfg.wrp_of;
  assign wrp_if             = w_cfg.wrp_if;

endmodule

// File: tb/tb_wrp_tap_ctrl.sv
// Bench for wrp_tap_ctrl: directed scans plus randomized IR/DR scans against a queue model.
module tb_wrp_tap_ctrl;
  import wrp_tap_pkg::*;

  logic TDR_TCK = 1'b0;
  logic TDR_TRESETN = 1'b0;
  logic TMS = 1'b1;
  logic TDI = 1'b0;
  logic WRP_SO = 1'b0;
  logic TDO, TDO_EN, TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE;
  logic INSCANWRAP_TDR_EN, OUTSCANWRAP_TDR_EN, WRP_SI;
  logic safe_val, inscanwrap_sel, wrp_of, wrp_if;

  wrp_tap_ctrl dut (
    .TDR_TCK            (TDR_TCK),
    .TDR_TRESETN        (TDR_TRESETN),
    .TMS                (TMS),
    .TDI                (TDI),
    .WRP_SO             (WRP_SO),
    .TDO                (TDO),
    .TDO_EN             (TDO_EN),
    .TDR_CAPTURE        (TDR_CAPTURE),
    .TDR_SHIFT          (TDR_SHIFT),
    .TDR_UPDATE         (TDR_UPDATE),
    .INSCANWRAP_TDR_EN  (INSCANWRAP_TDR_EN),
    .OUTSCANWRAP_TDR_EN (OUTSCANWRAP_TDR_EN),
    .WRP_SI             (WRP_SI),
    .safe_val           (safe_val),
    .inscanwrap_sel     (inscanwrap_sel),
    .wrp_of             (wrp_of),
    .wrp_if             (wrp_if)
  );

  always #5 TDR_TCK = ~TDR_TCK;

  int n_checks = 0;
  int n_fail = 0;
  int n_cap = 0;
  int n_shift = 0;
  int n_upd = 0;

  // expected wrapper state
  logic [3:0] m_ir = 4'hF;
  logic [3:0] m_cfg = 4'h0;

  // strobe pulse counters, sampled mid-cycle
  always @(negedge TDR_TCK) begin
    if (TDR_CAPTURE) n_cap++;
    if (TDR_SHIFT)   n_shift++;
    if (TDR_UPDATE)  n_upd++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input logic tms, input logic tdi, input logic so);
    TMS = tms;
    TDI = tdi;
    WRP_SO = so;
    @(posedge TDR_TCK);
    @(negedge TDR_TCK);
    #1;
  endtask

  task automatic check_sel(input string tag);
    chk({tag, "_inscan_en"}, INSCANWRAP_TDR_EN, (m_ir == 4'h2));
    chk({tag, "_outscan_en"}, OUTSCANWRAP_TDR_EN, (m_ir == 4'h3));
    chk({tag, "_onehot"}, INSCANWRAP_TDR_EN & OUTSCANWRAP_TDR_EN, 0);
  endtask

  task automatic check_cfg(input string tag);
    chk(tag, {safe_val, inscanwrap_sel, wrp_of, wrp_if}, m_cfg);
  endtask

  // RTI -> Shift-IR, shift op, Update-IR, back to RTI
  task automatic scan_ir(input logic [3:0] op);
    logic [3:0] cap_v;
    cap_v = 4'b0001;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("ir_tdo", TDO, cap_v[i]);
      chk("ir_tdo_en", TDO_EN, 1);
      tick(i == 3, op[i], 1'b0);
    end
    TMS = 1'b1;
    TDI = 1'b0;
    @(posedge TDR_TCK);
    #1;
    check_sel("pre_upd_ir");
    @(negedge TDR_TCK);
    #1;
    m_ir = op;
    check_sel("upd_ir");
    tick(1'b0, 1'b0, 1'b0);
  endtask

  // RTI -> Shift-DR for n bits, Update-DR, back to RTI
  task automatic scan_dr(input int n, input logic [15:0] bits);
    logic q[$];
    logic [16:0] so_v;
    logic chain, cfgsel, exp;
    so_v = 17'($urandom);
    chain = (m_ir == 4'h2) || (m_ir == 4'h3);
    cfgsel = (m_ir == 4'h4);
    q = {};
    if (cfgsel) for (int k = 0; k < 4; k++) q.push_back(m_cfg[k]);
    else q.push_back(1'b0);
    n_cap = 0;
    n_shift = 0;
    n_upd = 0;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, so_v[0]);
    for (int i = 0; i < n; i++) begin
      if (chain) exp = so_v[i];
      else begin
        exp = q.pop_front();
        q.push_back(bits[i]);
      end
      chk("dr_tdo", TDO, exp);
      chk("dr_tdo_en", TDO_EN, 1);
      tick(i == n - 1, bits[i], so_v[i+1]);
    end
    chk("exit_tdo_en", TDO_EN, 0);
    tick(1'b1, 1'b0, 1'b0);
    if (cfgsel) m_cfg = {q[3], q[2], q[1], q[0]};
    check_cfg("upd_dr_cfg");
    check_sel("dr_sel");
    tick(1'b0, 1'b0, 1'b0);
    chk("shift_cycles", n_shift, n);
    chk("capture_pulses", n_cap, 1);
    chk("update_pulses", n_upd, 1);
  endtask

  // random TMS wander, then five ones must land in TLR from anywhere
  task automatic tlr_walk();
    int k;
    k = $urandom_range(0, 12);
    for (int i = 0; i < k; i++) tick(1'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'($urandom), 1'b0);
    m_ir = 4'hF;
    m_cfg = 4'h0;
    chk("tlr_state", dut.r_state, TS_TLR);
    check_cfg("tlr_cfg");
    check_sel("tlr_sel");
    tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] op;
    int sel;

    // reset state
    #23;
    chk("rst_tdo", TDO, 0);
    chk("rst_tdo_en", TDO_EN, 0);
    check_cfg("rst_cfg");
    check_sel("rst_sel");
    @(negedge TDR_TCK);
    #1;
    TDR_TRESETN = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("rti_state", dut.r_state, TS_RTI);
    chk("rti_ir", dut.r_ir, 4'hF);
    chk("rti_strobes", {TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE}, 0);
    chk("rti_tdo_en", TDO_EN, 0);
    check_sel("rti_sel");

    // inscan select; IR capture returns 1,0,0,0
    scan_ir(4'h2);
    chk("inscan_en", INSCANWRAP_TDR_EN, 1);

    // config write 1010 then read back
    scan_ir(4'h4);
    scan_dr(4, 16'h000A);
    chk("safe_val", safe_val, 1);
    chk("inscanwrap_sel", inscanwrap_sel, 0);
    chk("wrp_of", wrp_of, 1);
    chk("wrp_if", wrp_if, 0);
    scan_dr(4, 16'h000A);

    // bypass: 1,0,1,1 appears one TCK late
    scan_ir(4'hF);
    scan_dr(5, 16'h000D);
    check_cfg("cfg_hold_bypass");

    // outscan: 5 shift cycles, TDO follows WRP_SO
    scan_ir(4'h3);
    scan_dr(5, 16'($urandom));
    check_cfg("cfg_hold_outscan");

    // reset mid-shift of the config TDR
    scan_ir(4'h4);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    #2;
    TDR_TRESETN = 1'b0;
    #1;
    m_ir = 4'hF;
    m_cfg = 4'h0;
    chk("midrst_state", dut.r_state, TS_TLR);
    check_cfg("midrst_cfg");
    chk("midrst_tdo", TDO, 0);
    chk("midrst_tdo_en", TDO_EN, 0);
    chk("midrst_shift", TDR_SHIFT, 0);
    check_sel("midrst_sel");
    @(negedge TDR_TCK);
    #1;
    TDR_TRESETN = 1'b1;
    tick(1'b0, 1'b0, 1'b0);

    // randomized scans
    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: op = 4'h2;
        1: op = 4'h3;
        2: op = 4'h4;
        3: op = 4'hF;
        default: begin
          op = 4'($urandom_range(5, 14));
          if ($urandom_range(0, 1) == 1) op = 4'($urandom_range(0, 1));
        end
      endcase
      scan_ir(op);
      scan_dr($urandom_range(1, 8), 16'($urandom));
      if ($urandom_range(0, 3) == 0) tlr_walk();
    end
    tlr_walk();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/wrp_tap_ctrl.md
WRP_TAP_CTRL -- requirements
Module: wrp_tap_ctrl

Interface
REQ-001 SHALL have parameter IR_LEN, default 4, instruction register width.
REQ-002 SHALL have parameter OP_INSCAN, default 4'h2, opcode that selects the input scan wrapper chain.
REQ-003 SHALL have parameter OP_OUTSCAN, default 4'h3, opcode that selects the output scan wrapper chain.
REQ-004 SHALL have parameter OP_WRPCFG, default 4'h4, opcode that selects the wrapper config TDR; all-ones is BYPASS.
REQ-005 SHALL have port TDR_TCK  in  1  test clock.
REQ-006 SHALL have port TDR_TRESETN  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have ports TMS  in  1  mode select; TDI  in  1  serial in.
REQ-008 SHALL have port WRP_SO  in  1  serial return from the wrapper chain CTO.
REQ-009 SHALL have ports TDO  out  1  serial out; TDO_EN  out  1  output enable.
REQ-010 SHALL have ports TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE  out  1 each  DR-phase strobes to the wrapper cells.
REQ-011 SHALL have ports INSCANWRAP_TDR_EN, OUTSCANWRAP_TDR_EN  out  1 each  chain selects.
REQ-012 SHALL have ports WRP_SI  out  1  serial feed to the chain CTI (equals TDI).
REQ-013 SHALL have ports safe_val, inscanwrap_sel, wrp_of, wrp_if  out  1 each  config TDR outputs.

Function
REQ-014 SHALL implement the 16-state IEEE 1149.1 TAP FSM, advancing on posedge TDR_TCK per TMS; five consecutive TMS=1 SHALL reach Test-Logic-Reset (TLR) from any state.
REQ-015 SHALL drive TDR_CAPTURE=1 in Capture-DR only, TDR_SHIFT=1 in Shift-DR only and TDR_UPDATE=1 in Update-DR only, each decoded from the state register without extra latency.
REQ-016 SHALL, in Capture-IR, load the IR shift register with 'b0...01, shift LSB-first from TDI in Shift-IR, and transfer to the IR on negedge TDR_TCK in Update-IR.
REQ-017 SHALL drive INSCANWRAP_TDR_EN=(IR==OP_INSCAN) and OUTSCANWRAP_TDR_EN=(IR==OP_OUTSCAN); at most one SHALL ever be 1.
REQ-018 SHALL treat any undefined opcode as BYPASS.
REQ-019 SHALL implement a 4-bit config TDR {safe_val, inscanwrap_sel, wrp_of, wrp_if} (bit0=wrp_if), selected by OP_WRPCFG.
REQ-020 Config TDR SHALL capture its current update-stage value in Capture-DR, shift LSB-first in Shift-DR, and load its update stage on negedge TDR_TCK in Update-DR.
REQ-021 Config outputs SHALL change only in Update-DR while OP_WRPCFG is active; they SHALL hold through IR changes.
REQ-022 BYPASS SHALL be a 1-bit register cleared in Capture-DR and loaded from TDI in Shift-DR.
REQ-023 SHALL select the TDO source as: Shift-IR -> IR shift LSB; Shift-DR with INSCAN/OUTSCAN -> WRP_SO; Shift-DR with WRPCFG -> config shift LSB; Shift-DR otherwise -> bypass bit.
REQ-024 SHALL register TDO and TDO_EN on negedge TDR_TCK; TDO_EN=1 only when the state registered on that edge was Shift-IR or Shift-DR.
REQ-025 SHALL give an IR load in the same Update-IR as a TMS excursion no glitch on the chain enables; the enables SHALL change only on that negedge.

Reset
REQ-026 SHALL, while TDR_TRESETN=0, force the state to TLR, IR to BYPASS (all ones), config TDR (shift and update stages) to 0, bypass bit to 0, TDO=0 and TDO_EN=0.
REQ-027 SHALL, on entry to TLR via TMS, apply the same IR and config values as REQ-026 on the next negedge.
REQ-028 SHALL, on reset mid-shift, discard the partial shift contents; outputs SHALL return to reset values immediately.

Structure
REQ-029 SHALL place the TAP state enum, opcode constants and IR_LEN default in the shared package wrp_tap_pkg.
REQ-030 SHALL contain one sub-module, wrp_cfg_tdr, holding the config shift and update stages.

Verification
REQ-031 SHALL verify: reset, then TMS=0 for 1 cycle -> Run-Test/Idle; IR=4'hF; all enables 0; TDO_EN=0.
REQ-032 SHALL verify: shift IR 4'h2, then Update-IR -> INSCANWRAP_TDR_EN=1 at that negedge; IR capture shifted out on TDO as 1,0,0,0.
REQ-033 SHALL verify: with OP_WRPCFG, shift 4'b1010 then Update-DR -> safe_val=1, inscanwrap_sel=0, wrp_of=1, wrp_if=0; next DR scan returns 1010 on TDO.
REQ-034 SHALL verify: with BYPASS, shift pattern 1,0,1,1 -> TDO shows the same pattern delayed by 1 TCK.
REQ-035 SHALL verify: with OP_OUTSCAN and a 5-cycle Shift-DR -> TDR_SHIFT=1 for exactly 5 cycles; TDO follows WRP_SO; TDR_CAPTURE and TDR_UPDATE pulse once each.
REQ-036 SHALL verify: TDR_TRESETN low during Shift-DR of the config TDR -> state TLR and all config outputs 0 with no TCK edge.
